// File: rtl/multi_timer.sv
// -----------------------------------------------------------------------------
// multi_timer
//  Multi-channel interrupt timer for the Z80 side. One shared prescaler drives a
//  free-running base counter; each channel taps a base-counter bit selected by
//  its rate field, divides those events by (reload+1) and raises a pending flag
//  (with sticky overrun) when it fires. The interrupt controller sees the
//  lowest-numbered pending channel on int_req/int_vec.
//
// Ports
//  clk_24mhz    in   1                  clock, rising edge
//  rst_n        in   1                  asynchronous active-low reset
//  cfg_we       in   1                  channel config write strobe
//  cfg_ch       in   CH_W               channel index for cfg_we
//  cfg_data     in   2+RATE_W+RELOAD_W  {en, oneshot, rate, reload}
//  ack_stb      in   1                  acknowledge strobe
//  ack_ch       in   CH_W               channel index for ack_stb
//  int_stb      out  1                  one-cycle pulse after any channel fires
//  int_pending  out  NCH                per-channel pending flags
//  int_ovf      out  NCH                per-channel sticky overrun flags
//  int_req      out  1                  any channel pending (combinational)
//  int_vec      out  CH_W               lowest pending channel, 0 if none
// -----------------------------------------------------------------------------
module multi_timer #(
   parameter int unsigned NCH      = 4,
   parameter int unsigned PRESC    = 5,
   parameter int unsigned CTR_W    = 17,
   parameter int unsigned BASE_TAP = 6,
   parameter int unsigned RATE_W   = 4,
   parameter int unsigned RELOAD_W = 8
) (
   input  logic                                    clk_24mhz,
   input  logic                                    rst_n,
   input  logic                                    cfg_we,
   input  logic [$clog2((NCH > 1) ? NCH : 2)-1:0]  cfg_ch,
   input  logic [2+RATE_W+RELOAD_W-1:0]            cfg_data,
   input  logic                                    ack_stb,
   input  logic [$clog2((NCH > 1) ? NCH : 2)-1:0]  ack_ch,
   output logic                                    int_stb,
   output logic [NCH-1:0]                          int_pending,
   output logic [NCH-1:0]                          int_ovf,
   output logic                                    int_req,
   output logic [$clog2((NCH > 1) ? NCH : 2)-1:0]  int_vec
);

   // A single-channel build still gets a 1-bit index so no port collapses to zero width.
   localparam int unsigned CH_W    = $clog2((NCH > 1) ? NCH : 2);
   localparam int unsigned PRESC_W = $clog2((PRESC > 1) ? PRESC : 2);

   typedef struct packed {
      logic                en;
      logic                oneshot;
      logic [RATE_W-1:0]   rate;
      logic [RELOAD_W-1:0] reload;
   } ch_cfg_t;

   ch_cfg_t cfg_c;
   assign cfg_c = ch_cfg_t'(cfg_data);

   // Shared time base
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [CTR_W-1:0]   base_q,  base_d;
   logic               tick_c;

   // Per-channel state
   logic [NCH-1:0]      en_q,   en_d;
   logic [NCH-1:0]      os_q,   os_d;
   logic [RATE_W-1:0]   rate_q   [NCH];
   logic [RATE_W-1:0]   rate_d   [NCH];
   logic [RELOAD_W-1:0] reload_q [NCH];
   logic [RELOAD_W-1:0] reload_d [NCH];
   logic [RELOAD_W-1:0] cnt_q    [NCH];
   logic [RELOAD_W-1:0] cnt_d    [NCH];
   logic [NCH-1:0]      pend_q, pend_d;
   logic [NCH-1:0]      ovf_q,  ovf_d;
   logic                stb_q,  stb_d;

   logic [NCH-1:0]      ev_c;
   logic [NCH-1:0]      fire_c;
   logic [NCH-1:0]      cfg_hit_c;
   logic [NCH-1:0]      ack_hit_c;

   // True when base[k:0] is all ones, k = min(BASE_TAP+rate, CTR_W-1): bit k falls on the next tick.
   function automatic logic tap_event(input logic [CTR_W-1:0]  base,
                                      input logic [RATE_W-1:0] rate);
      int unsigned      k;
      logic [CTR_W-1:0] m;
      k = BASE_TAP + 32'(rate);
      if (k > CTR_W - 1) k = CTR_W - 1;
      m = '0;
      for (int unsigned b = 0; b < CTR_W; b++) m[b] = (b <= k);
      return (base & m) == m;
   endfunction

   // Prescaler and free-running base counter
   assign tick_c  = (presc_q == PRESC_W'(PRESC - 1));
   assign presc_d = tick_c ? '0 : presc_q + PRESC_W'(1);
   assign base_d  = tick_c ? base_q + CTR_W'(1) : base_q;

   // Strobe decode; out-of-range indices match no channel
   always_comb begin
      cfg_hit_c = '0;
      ack_hit_c = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         cfg_hit_c[i] = cfg_we  && (cfg_ch == CH_W'(i));
         ack_hit_c[i] = ack_stb && (ack_ch == CH_W'(i));
      end
   end

   // Channel base events
   always_comb begin
      ev_c = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         ev_c[i] = tick_c && tap_event(base_q, rate_q[i]);
      end
   end

   // Channel next state: config write beats fire, fire beats ack
   always_comb begin
      en_d     = en_q;
      os_d     = os_q;
      rate_d   = rate_q;
      reload_d = reload_q;
      cnt_d    = cnt_q;
      pend_d   = pend_q;
      ovf_d    = ovf_q;
      fire_c   = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (cfg_hit_c[i]) begin
            en_d[i]     = cfg_c.en;
            os_d[i]     = cfg_c.oneshot;
            rate_d[i]   = cfg_c.rate;
            reload_d[i] = cfg_c.reload;
            cnt_d[i]    = cfg_c.reload;
            pend_d[i]   = 1'b0;
            ovf_d[i]    = 1'b0;
         end else begin
            if (en_q[i] && ev_c[i]) begin
               if (cnt_q[i] == '0) begin
                  fire_c[i] = 1'b1;
                  cnt_d[i]  = reload_q[i];
                  pend_d[i] = 1'b1;
                  // An ack landing with the fire consumes the old request, so no overrun.
                  if (pend_q[i] && !ack_hit_c[i]) ovf_d[i] = 1'b1;
                  if (os_q[i]) en_d[i] = 1'b0;
               end else begin
                  cnt_d[i] = cnt_q[i] - RELOAD_W'(1);
               end
            end
            if (ack_hit_c[i] && pend_q[i] && !fire_c[i]) begin
               pend_d[i] = 1'b0;
               ovf_d[i]  = 1'b0;
            end
         end
      end
   end

   assign stb_d = |fire_c;

   // State registers
   always_ff @(posedge clk_24mhz or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= '0;
         base_q  <= '0;
         en_q    <= '0;
         os_q    <= '0;
         pend_q  <= '0;
         ovf_q   <= '0;
         stb_q   <= 1'b0;
         for (int unsigned i = 0; i < NCH; i++) begin
            rate_q[i]   <= '0;
            reload_q[i] <= '0;
            cnt_q[i]    <= '0;
         end
      end else begin
         presc_q  <= presc_d;
         base_q   <= base_d;
         en_q     <= en_d;
         os_q     <= os_d;
         pend_q   <= pend_d;
         ovf_q    <= ovf_d;
         stb_q    <= stb_d;
         rate_q   <= rate_d;
         reload_q <= reload_d;
         cnt_q    <= cnt_d;
      end
   end

   // Lowest-index pending channel wins
   always_comb begin
      int_vec = '0;
      for (int i = int'(NCH) - 1; i >= 0; i--) begin
         if (pend_q[i]) int_vec = CH_W'(i);
      end
   end

   assign int_stb     = stb_q;
   assign int_pending = pend_q;
   assign int_ovf     = ovf_q;
   assign int_req     = |pend_q;

endmodule
